fc_input_feeder: RTL
====================

Name: fc_input_feeder

Overview:
- Transmit-side partner of the first fully-connected layer's 3-channel input port.
- Collects pooled feature maps from the pooling stage: three 12-bit channels arrive in parallel, 16 positions per frame.
- Stores each frame in a ping-pong buffer, then streams it to the FC layer as 16 back-to-back data beats.
- Follows the data beats with the output-step beats the FC layer needs to advance through its 16 outputs.

Parameters:
- BEATS, 16: positions per channel per frame (data beats per frame).
- STEP_BEATS, 15: valid-only beats after the data beats; each advances the FC output index.
- DATA_BITS, 12: width of each channel sample.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- valid_in, input, 1: a pooled sample triple is present.
- data_in_1, data_in_2, data_in_3, input, DATA_BITS each, signed: channel 0/1/2 sample.
- ready_in, output, 1: write bank can accept a sample.
- valid_out, output, 1: beat valid to the FC layer.
- data_out_1, data_out_2, data_out_3, output, DATA_BITS each, signed: channel 0/1/2 beat data.
- frame_done, output, 1: one-cycle pulse after the last beat of a frame.
- drop_err, output, 1: sticky flag, set when a sample is offered while ready_in=0.

Behaviour:
- Reset values: valid_out=0, data_out_*=0, frame_done=0, drop_err=0, ready_in=1.
- Reset also clears: both bank-full flags, wr_bank=0, rd_bank=0, all counters, FSM=IDLE.
- Reset mid-frame discards any partial or queued frame. Buffer contents need not be cleared.

Storage:
- Two banks, each BEATS x 3 x DATA_BITS.

Write side:
- ready_in = !full[wr_bank] (combinational).
- Sample accepted when valid_in && ready_in: write into wr_bank at wr_idx, then wr_idx++.
- On the BEATS-th accept: set full[wr_bank], toggle wr_bank, wr_idx=0.
- valid_in && !ready_in: sample dropped, drop_err<=1 until reset.

Transmit FSM:
- IDLE: if full[rd_bank], go to SEND next cycle with rd_idx=0.
- SEND: valid_out=1, data_out_* = bank[rd_bank][rd_idx], registered.
  - One beat per cycle, no gaps, no backpressure.
  - After beat BEATS-1, go to STEP.
- STEP: valid_out=1, data_out_*=0, for STEP_BEATS cycles, then go to DONE.
- DONE: clear full[rd_bank], toggle rd_bank, frame_done=1 for one cycle, valid_out=0, go to IDLE.
- If the other bank is already full, IDLE leaves for SEND on the following cycle.
  - Result: 1 dead cycle in DONE plus 1 in IDLE between frames.

Latency and boundary cases:
- Latency: 16th accepted write at cycle N, tx idle → first valid_out at cycle N+2 (N+1 sets full, IDLE sees it).
- Simultaneous 16th write into bank A and DONE releasing bank B, same cycle: both flag updates apply. ready_in stays 1 throughout.
- Both banks full: ready_in=0 until DONE clears the read bank. ready_in returns to 1 on the cycle after DONE.
- Index wrap: wr_idx and rd_idx wrap at BEATS-1 → 0. The step counter is independent.
- Order: data_out_k carries channel k, position rd_idx, ascending from 0. The receiver places channel k at k*BEATS+idx.

Optional Feature:
- Macro: FC_INPUT_FEEDER_STEP_EN.
- Defined: STEP state present as above; 16+STEP_BEATS valid cycles per frame.
- Undefined: STEP state omitted; SEND goes directly to DONE after beat BEATS-1; 16 valid cycles per frame. STEP_BEATS is unused.

Test Plan:
- Reset, then one frame of 16 triples with data_in_1=i, data_in_2=0x100+i, data_in_3=-i, i=0..15 → valid_out high 31 consecutive cycles (STEP_EN defined).
  - First 16 beats match the written order.
  - Last 15 beats have data=0.
  - frame_done pulses on cycle 32; first valid_out 2 cycles after the 16th write.
- Same frame with macro undefined → exactly 16 valid cycles, then frame_done.
- Three frames written back-to-back with valid_in held high 48 cycles:
  - ready_in drops after the 32nd write and recovers after frame 1's DONE.
  - No drop_err when the source honours ready_in.
  - All 3 frames transmitted intact in order.
- Same three frames, valid_in ignoring ready_in → drop_err=1, and the frame with dropped samples is not corrupted beyond the dropped positions.
- rst pulsed mid-SEND at beat 7 → valid_out=0 on the next cycle; both banks empty; ready_in=1.
  - A fresh frame afterwards transmits correctly from position 0.
- 16th write into bank A on the same cycle bank B's DONE occurs → ready_in never deasserts; bank A transmits 2 cycles later.

Source files
------------

// File: rtl/fc_input_feeder.sv
// fc_input_feeder
//   Transmit-side feeder for the first fully-connected layer's 3-channel input.
//   Pooled sample triples are collected into a ping-pong buffer (one bank per
//   frame of BEATS positions). Each full bank is streamed as BEATS back-to-back
//   data beats, optionally followed by STEP_BEATS zero-data "step" beats that
//   advance the FC layer through its outputs.
//
// Build option:
//   FC_INPUT_FEEDER_STEP_EN  defined   -> step beats follow the data beats
//                            undefined -> data beats only (STEP_BEATS unused)
//
// Ports:
//   clk                      clock, rising edge
//   rst                      synchronous reset, active-high
//   valid_in                 sample triple present
//   data_in_1/2/3            channel 0/1/2 sample (signed, DATA_BITS)
//   ready_in                 current write bank can accept a sample
//   valid_out                beat valid to the FC layer
//   data_out_1/2/3           channel 0/1/2 beat data (signed, DATA_BITS)
//   frame_done               one-cycle pulse after the last beat of a frame
//   drop_err                 sticky: a sample was offered while ready_in=0
//
// Transmit FSM:
//   state   | meaning
//   IDLE    | wait for the read bank to become full
//   SEND    | stream bank[rd_bank][rd_idx], one beat per cycle
//   STEP    | zero-data valid beats (only with FC_INPUT_FEEDER_STEP_EN)
//   DONE    | release the read bank, pulse frame_done, swap rd_bank

module fc_input_feeder #(
  parameter int BEATS      = 16,
  parameter int STEP_BEATS = 15,
  parameter int DATA_BITS  = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  input  logic signed [DATA_BITS-1:0] data_in_1,
  input  logic signed [DATA_BITS-1:0] data_in_2,
  input  logic signed [DATA_BITS-1:0] data_in_3,
  output logic                        ready_in,
  output logic                        valid_out,
  output logic signed [DATA_BITS-1:0] data_out_1,
  output logic signed [DATA_BITS-1:0] data_out_2,
  output logic signed [DATA_BITS-1:0] data_out_3,
  output logic                        frame_done,
  output logic                        drop_err
);

  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Address is {bank, idx}; depth rounds each bank up to a power of two.
  localparam int DEPTH = 2 ** (IDX_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
`ifdef FC_INPUT_FEEDER_STEP_EN
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam int STEP_W = $clog2(STEP_BEATS + 1);
`endif
  localparam logic [1:0] ST_DONE = 2'd3;

  logic signed [DATA_BITS-1:0] mem_c0 [DEPTH];
  logic signed [DATA_BITS-1:0] mem_c1 [DEPTH];
  logic signed [DATA_BITS-1:0] mem_c2 [DEPTH];

  logic [1:0]       full;
  logic             wr_bank;
  logic             rd_bank;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [1:0]       state;
`ifdef FC_INPUT_FEEDER_STEP_EN
  logic [STEP_W-1:0] step_cnt;
`endif

  logic accept;
  logic wr_last;

  assign ready_in = ~full[wr_bank];
  assign accept   = valid_in & ready_in;
  assign wr_last  = accept & (wr_idx == LAST_IDX);

  // Sample storage; contents survive reset on purpose, the flags gate reuse.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_c0[{wr_bank, wr_idx}] <= data_in_1;
      mem_c1[{wr_bank, wr_idx}] <= data_in_2;
      mem_c2[{wr_bank, wr_idx}] <= data_in_3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx   <= '0;
      wr_bank  <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      if (accept) begin
        if (wr_idx == LAST_IDX) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
      if (valid_in && !ready_in) begin
        drop_err <= 1'b1;
      end
    end
  end

  // A bank being filled is never the bank being released (DONE only occurs
  // on a full bank, writes only go to an empty one), so both updates can
  // land on the same edge without conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
    end else begin
      if (wr_last) begin
        full[wr_bank] <= 1'b1;
      end
      if (state == ST_DONE) begin
        full[rd_bank] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rd_bank    <= 1'b0;
      rd_idx     <= '0;
`ifdef FC_INPUT_FEEDER_STEP_EN
      step_cnt   <= '0;
`endif
      valid_out  <= 1'b0;
      data_out_1 <= '0;
      data_out_2 <= '0;
      data_out_3 <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          valid_out  <= 1'b0;
          data_out_1 <= '0;
          data_out_2 <= '0;
          data_out_3 <= '0;
          if (full[rd_bank]) begin
            state  <= ST_SEND;
            rd_idx <= '0;
          end
        end
        ST_SEND: begin
          valid_out  <= 1'b1;
          data_out_1 <= mem_c0[{rd_bank, rd_idx}];
          data_out_2 <= mem_c1[{rd_bank, rd_idx}];
          data_out_3 <= mem_c2[{rd_bank, rd_idx}];
          if (rd_idx == LAST_IDX) begin
            rd_idx <= '0;
`ifdef FC_INPUT_FEEDER_STEP_EN
            state    <= ST_STEP;
            step_cnt <= STEP_W'(STEP_BEATS - 1);
`else
            state <= ST_DONE;
`endif
          end else begin
            rd_idx <= rd_idx + 1'b1;
          end
        end
`ifdef FC_INPUT_FEEDER_STEP_EN
        ST_STEP: begin
          valid_out  <= 1'b1;
          data_out_1 <= '0;
          data_out_2 <= '0;
          data_out_3 <= '0;
          if (step_cnt == '0) begin
            state <= ST_DONE;
          end else begin
            step_cnt <= step_cnt - 1'b1;
          end
        end
`endif
        ST_DONE: begin
          valid_out  <= 1'b0;
          data_out_1 <= '0;
          data_out_2 <= '0;
          data_out_3 <= '0;
          frame_done <= 1'b1;
          rd_bank    <= ~rd_bank;
          state      <= ST_IDLE;
        end
        default: begin
          valid_out  <= 1'b0;
          data_out_1 <= '0;
          data_out_2 <= '0;
          data_out_3 <= '0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
